// File: rtl/logic_pipe.sv
// ----------------------------------------------------------------------------
// logic_pipe
//
// Purpose:
//    Bitwise logic unit followed by a DEPTH-stage elastic pipeline with
//    valid/ready handshakes on both sides. Each stage holds one result and a
//    valid bit. A stage moves forward when the stage ahead of it is empty or is
//    moving forward too. This lets bubbles close up while the output is
//    stalled, and it gives full throughput while the output is flowing.
//
// Parameters:
//    WIDTH  operand / result width in bits (1..64)
//    DEPTH  number of pipeline stages (1..8)
//
// Ports:
//    clock      single clock; all state changes on its rising edge
//    reset      synchronous, active-high reset
//    in_valid   upstream presents op/a/b
//    in_ready   the pipe accepts an operation this cycle
//    op         operation select (NOT a, AND, OR, XOR, NAND, NOR, XNOR, pass a)
//    a, b       operands
//    out_valid  out holds a valid result
//    out_ready  downstream accepts the result
//    out        result from the last stage
//    occupancy  number of stages currently holding a valid result
//
// Optional feature (macro LOGIC_PIPE_REDUCE_EN):
//    all_ones, any_one, is_zero
//               AND-, OR- and NOR-reduction of the stage-1 result. These flags
//               travel down the pipe alongside their result.
// ----------------------------------------------------------------------------
module logic_pipe #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [2:0]                     op,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out,
`ifdef LOGIC_PIPE_REDUCE_EN
   output logic                           all_ones,
   output logic                           any_one,
   output logic                           is_zero,
`endif
   output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

   localparam int OCC_W = $clog2(DEPTH + 1);

`ifdef LOGIC_PIPE_REDUCE_EN
   // The three reduction flags sit above the result bits in each stage word.
   localparam int PW = WIDTH + 3;
`else
   localparam int PW = WIDTH;
`endif

   logic [WIDTH-1:0] w_result;
   logic [PW-1:0]    w_stageIn;
   logic [DEPTH-1:0] w_adv;
   logic             w_room;
   logic             w_accept;

   logic [DEPTH-1:0] r_valid;
   logic [PW-1:0]    r_data [DEPTH];

   // Operation decode. The result is purely combinational and is captured
   // into stage 1 when an operation is accepted.
   always_comb begin
      w_result = '0;
      case (op)
         3'b000:  w_result = ~a;
         3'b001:  w_result = a & b;
         3'b010:  w_result = a | b;
         3'b011:  w_result = a ^ b;
         3'b100:  w_result = ~(a & b);
         3'b101:  w_result = ~(a | b);
         3'b110:  w_result = ~(a ^ b);
         default: w_result = a;
      endcase
   end

`ifdef LOGIC_PIPE_REDUCE_EN
   assign w_stageIn = {&w_result, |w_result, ~|w_result, w_result};
`else
   assign w_stageIn = w_result;
`endif

   // Advance computation, walking from the output back toward stage 1.
   // w_room means "something at or after the next stage can take a result
   // this cycle". That is true when the output is being taken or when any
   // later stage is empty. A valid stage advances exactly when there is room.
   // Evaluating it this way avoids a chain of w_adv bits feeding each other.
   always_comb begin
      w_room = out_ready;
      w_adv  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_adv[k] = r_valid[k] & w_room;
         w_room   = w_room | ~r_valid[k];
      end
   end

   // The block is never ready while reset is asserted. Otherwise it is ready
   // when stage 1 is free or is moving on. This gives the combinational path
   // from out_ready to in_ready.
   assign in_ready = ~reset & (~r_valid[0] | w_adv[0]);
   assign w_accept = in_valid & in_ready;

   // Stage registers. A stage loads from its predecessor (or from the logic
   // unit for stage 1) when that predecessor advances. A stage empties when
   // it advances without being refilled. Otherwise it holds, which keeps out
   // stable under back-pressure. Reset clears every stage and its data, so
   // out reads as zero afterwards.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_valid[0] <= 1'b1;
            r_data[0]  <= w_stageIn;
         end else if (w_adv[0]) begin
            r_valid[0] <= 1'b0;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (w_adv[k-1]) begin
               r_valid[k] <= 1'b1;
               r_data[k]  <= r_data[k-1];
            end else if (w_adv[k]) begin
               r_valid[k] <= 1'b0;
            end
         end
      end
   end

   // Occupancy is a population count of the stage valid bits. It therefore
   // always matches the number of results held and can never exceed DEPTH.
   always_comb begin
      occupancy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occupancy = occupancy + OCC_W'(r_valid[k]);
      end
   end

   assign out_valid = r_valid[DEPTH-1];
   assign out       = r_data[DEPTH-1][WIDTH-1:0];

`ifdef LOGIC_PIPE_REDUCE_EN
   assign all_ones = r_data[DEPTH-1][WIDTH+2];
   assign any_one  = r_data[DEPTH-1][WIDTH+1];
   assign is_zero  = r_data[DEPTH-1][WIDTH];
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// ----------------------------------------------------------------------------
// tb_logic_pipe
//
// Scoreboard bench for logic_pipe. Two instances are used: a WIDTH=16 /
// DEPTH=2 pipe for the directed and random sequences, and a WIDTH=8 / DEPTH=1
// pipe for a toggling-valid random run. Stimulus tasks push the expected
// result whenever a handshake is accepted. Independent monitors pop and
// compare whenever an output handshake occurs. The monitors also cross-check
// occupancy and in_ready against the number of results in flight.
// ----------------------------------------------------------------------------
module tb_logic_pipe;

   localparam int WIDTH = 16;
   localparam int DEPTH = 2;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  flags;
      int          cyc;
      bit          lat;
   } expT;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  op;
   logic [15:0] a, b, out;
   logic [1:0]  occupancy;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, out8;
   logic [0:0]  occupancy8;

`ifdef LOGIC_PIPE_REDUCE_EN
   logic        all_ones, any_one, is_zero;
   logic        all_ones8, any_one8, is_zero8;
`endif

   expT         q1[$];
   logic [7:0]  q2[$];
   expT         e1;
   logic [7:0]  e2;
   int          nCompared   = 0;
   int          nMismatched = 0;
   int          cycle       = 0;
   bit          monEn       = 1'b0;
   bit          prevStall1  = 1'b0;
   bit          prevStall2  = 1'b0;
   bit          prevReset   = 1'b1;
   logic [15:0] prevOut1;
   logic [7:0]  prevOut2;

   logic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
`ifdef LOGIC_PIPE_REDUCE_EN
      .all_ones  (all_ones),
      .any_one   (any_one),
      .is_zero   (is_zero),
`endif
      .occupancy (occupancy)
   );

   logic_pipe #(.WIDTH(8), .DEPTH(1)) u_dut8 (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .op        (op8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out       (out8),
`ifdef LOGIC_PIPE_REDUCE_EN
      .all_ones  (all_ones8),
      .any_one   (any_one8),
      .is_zero   (is_zero8),
`endif
      .occupancy (occupancy8)
   );

   // Free-running clock and a cycle counter used for latency measurement.
   initial forever #5 clock = ~clock;
   initial forever begin
      @(posedge clock);
      cycle++;
   end

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: bitwise operations taken straight from the op table.
   function automatic logic [63:0] refOp(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
      case (o)
         3'd0:    return ~x;
         3'd1:    return x & y;
         3'd2:    return x | y;
         3'd3:    return x ^ y;
         3'd4:    return ~(x & y);
         3'd5:    return ~(x | y);
         3'd6:    return ~(x ^ y);
         default: return x;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // One cycle of stimulus on the 16-bit pipe. Inputs change just after the
   // rising edge. The accept decision is read mid-cycle, and the expected
   // result is queued when the handshake will occur.
   task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [15:0] x,
                                input logic [15:0] y, input logic ordy, input bit lat,
                                output bit accepted);
      expT         e;
      logic [63:0] t;
      @(posedge clock); #1;
      in_valid  = v;
      op        = o;
      a         = x;
      b         = y;
      out_ready = ordy;
      @(negedge clock); #1;
      accepted = in_valid && in_ready;
      if (accepted) begin
         t       = refOp(o, {48'd0, x}, {48'd0, y});
         e.data  = t[15:0];
         e.flags = {&e.data, |e.data, ~|e.data};
         e.cyc   = cycle;
         e.lat   = lat;
         q1.push_back(e);
      end
   endtask

   task automatic sendOp(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic ordy, input bit lat, output int tries);
      bit acc = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
         applyStimulus(1'b1, o, x, y, ordy, lat, acc);
         tries++;
      end
      checkOutput("sendOp accepted", acc, 1);
   endtask

   task automatic idle(input int n, input logic ordy);
      bit acc;
      repeat (n) applyStimulus(1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), ordy, 1'b0, acc);
   endtask

   task automatic drain();
      int n = 0;
      bit acc;
      while (q1.size() != 0 && n < 100) begin
         applyStimulus(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
         n++;
      end
      checkOutput("drain empties pipe", q1.size(), 0);
   endtask

   // One cycle of stimulus on the 8-bit, single-stage pipe.
   task automatic step8(input logic v, input logic [2:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic ordy);
      logic [63:0] t;
      @(posedge clock); #1;
      in_valid8  = v;
      op8        = o;
      a8         = x;
      b8         = y;
      out_ready8 = ordy;
      @(negedge clock); #1;
      if (in_valid8 && in_ready8) begin
         t = refOp(o, {56'd0, x}, {56'd0, y});
         q2.push_back(t[7:0]);
      end
   endtask

   // Synchronous reset held for n edges. Scoreboards are flushed as each
   // reset edge discards everything in flight.
   task automatic resetDut(input int n);
      @(posedge clock); #1;
      reset      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b0;
      repeat (n) begin
         @(negedge clock); #1;
         checkOutput("in_ready during reset", in_ready, 0);
         checkOutput("in_ready8 during reset", in_ready8, 0);
         @(posedge clock); #1;
         q1.delete();
         q2.delete();
      end
      reset = 1'b0;
      monEn = 1'b1;
      @(negedge clock); #1;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset occupancy", occupancy, 0);
      checkOutput("reset out", out, 0);
      checkOutput("in_ready after reset", in_ready, 1);
      checkOutput("reset out_valid8", out_valid8, 0);
      checkOutput("reset out8", out8, 0);
      checkOutput("in_ready8 after reset", in_ready8, 1);
`ifdef LOGIC_PIPE_REDUCE_EN
      checkOutput("reset flags", {all_ones, any_one, is_zero}, 3'b000);
`endif
   endtask

   // Monitor for the 16-bit pipe. Results in flight are exactly the queued
   // entries. So occupancy must equal the queue depth, and in_ready must be
   // 1 unless the pipe is full with output stalled (or reset is high).
   initial forever begin
      @(negedge clock);
      if (monEn) begin
         checkOutput("occupancy", occupancy, q1.size());
         checkOutput("in_ready", in_ready, !reset && (q1.size() < DEPTH || out_ready));
         if (prevStall1 && !prevReset) begin
            checkOutput("stall holds out_valid", out_valid, 1);
            checkOutput("stall holds out", out, prevOut1);
         end
         if (out_valid && out_ready && !reset) begin
            checkOutput("result expected", q1.size() > 0, 1);
            if (q1.size() > 0) begin
               e1 = q1.pop_front();
               checkOutput("result", out, e1.data);
`ifdef LOGIC_PIPE_REDUCE_EN
               checkOutput("reduce flags", {all_ones, any_one, is_zero}, e1.flags);
`endif
               if (e1.lat) checkOutput("latency", cycle - e1.cyc, DEPTH);
            end
         end
         prevStall1 = out_valid && !out_ready;
         prevOut1   = out;
      end
   end

   // Monitor for the 8-bit, single-stage pipe.
   initial forever begin
      @(negedge clock);
      if (monEn) begin
         checkOutput("occupancy8", occupancy8, q2.size());
         checkOutput("in_ready8", in_ready8, !reset && (q2.size() < 1 || out_ready8));
         if (prevStall2 && !prevReset) begin
            checkOutput("stall holds out_valid8", out_valid8, 1);
            checkOutput("stall holds out8", out8, prevOut2);
         end
         if (out_valid8 && out_ready8 && !reset) begin
            checkOutput("result8 expected", q2.size() > 0, 1);
            if (q2.size() > 0) begin
               e2 = q2.pop_front();
               checkOutput("result8", out8, e2);
            end
         end
         prevStall2 = out_valid8 && !out_ready8;
         prevOut2   = out8;
         prevReset  = reset;
      end
   end

   // Directed and random sequences.
   initial begin
      logic [15:0] opA [8];
      int          tries;
      bit          acc;
      int          n;
      in_valid   = 1'b0;
      op         = 3'd0;
      a          = '0;
      b          = '0;
      out_ready  = 1'b0;
      in_valid8  = 1'b0;
      op8        = 3'd0;
      a8         = '0;
      b8         = '0;
      out_ready8 = 1'b0;

      resetDut(3);

      // Single AND with a free-flowing output; latency is checked by the monitor.
      sendOp(3'b001, 16'hF0F0, 16'hFF00, 1'b1, 1'b1, tries);
      idle(4, 1'b1);

      // All eight ops back to back; each must be taken on its first cycle.
      for (int i = 0; i < 8; i++) begin
         sendOp(3'(i), 16'h00FF, 16'h0F0F, 1'b1, 1'b1, tries);
         checkOutput("throughput", tries, 1);
      end

      // Pass-through of the all-zero and all-one patterns (reduction flags).
      sendOp(3'b111, 16'h0000, 16'h1234, 1'b1, 1'b1, tries);
      sendOp(3'b111, 16'hFFFF, 16'h0000, 1'b1, 1'b1, tries);
      drain();

      // Output stalled: two ops fill the pipe and the third one waits.
      sendOp(3'b011, 16'hA5A5, 16'h0FF0, 1'b0, 1'b0, tries);
      sendOp(3'b100, 16'h1234, 16'hFF00, 1'b0, 1'b0, tries);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 3'b110, 16'hCAFE, 16'h00FF, 1'b0, 1'b0, acc);
         checkOutput("third op stalls", acc, 0);
         checkOutput("full occupancy", occupancy, 2);
         checkOutput("full in_ready", in_ready, 0);
      end
      sendOp(3'b110, 16'hCAFE, 16'h00FF, 1'b1, 1'b0, tries);
      drain();

      // Reset while full; only the first accept after reset may come out.
      sendOp(3'b010, 16'h0F00, 16'h00F0, 1'b0, 1'b0, tries);
      sendOp(3'b000, 16'h5555, 16'h0000, 1'b0, 1'b0, tries);
      resetDut(1);
      sendOp(3'b101, 16'h8001, 16'h4002, 1'b1, 1'b1, tries);
      idle(4, 1'b1);
      drain();

      // Random traffic with random back-pressure on the 16-bit pipe.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                       16'($urandom), ($urandom_range(0, 3) != 0), 1'b0, acc);
      end
      drain();

      // Single-stage 8-bit pipe: valid toggles every other cycle, random ready.
      for (int i = 0; i < 300; i++) begin
         step8((i % 2) == 0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)));
      end
      n = 0;
      while (q2.size() != 0 && n < 50) begin
         step8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
         n++;
      end
      checkOutput("drain8 empties pipe", q2.size(), 0);

      idle(2, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: operand and result width in bits, legal values 1..64.
REQ-002 SHALL provide parameter DEPTH, default 2: number of pipeline stages, legal values 1..8.
REQ-003 SHALL have port clock, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream operands and op are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 SHALL have port op, input, 3 bits: operation select.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-009 SHALL have port out_valid, output, 1 bit: out holds a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out, output, WIDTH bits: the result.
REQ-012 SHALL have port occupancy, output, clog2(DEPTH+1) bits: the number of valid stages currently held.

Function
REQ-013 SHALL decode op as follows: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 pass a. All operations are bitwise over WIDTH bits.
REQ-014 SHALL accept an operation on any cycle where in_valid and in_ready are both 1; the result is computed combinationally and captured into stage 1.
REQ-015 SHALL advance stage k into stage k+1 when stage k+1 is empty or is itself advancing; stage DEPTH advances when out_ready is 1.
REQ-016 SHALL drive in_ready as: stage 1 empty, or stage 1 advancing in the same cycle. There is a combinational path from out_ready to in_ready.
REQ-017 SHALL have a latency of exactly DEPTH cycles from acceptance to out_valid when out_ready is held at 1.
REQ-018 SHALL sustain a throughput of one operation per cycle when in_valid and out_ready are both held at 1.
REQ-019 SHALL hold out and out_valid stable while out_valid is 1 and out_ready is 0.
REQ-020 SHALL never drop, duplicate or reorder results.
REQ-021 SHALL, when the pipe is full and out_ready is 0, drive in_ready to 0; no stage changes state.
REQ-022 SHALL, on a simultaneous accept and emit, leave occupancy unchanged.
REQ-023 SHALL keep occupancy equal to the number of valid stages at all times; it never exceeds DEPTH.
REQ-024 SHALL ignore a, b and op on any cycle where in_valid is 0. Bubbles propagate and compress when downstream is stalled.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, clear every stage valid bit, so out_valid=0 and occupancy=0 after that edge.
REQ-026 SHALL drive out=0 after reset.
REQ-027 SHALL discard any in-flight results on reset mid-operation.
REQ-028 SHALL drive in_ready=0 during any cycle in which reset=1, and drive in_ready=1 on the first cycle after reset is released.

Configuration
REQ-029 SHALL, when macro LOGIC_PIPE_REDUCE_EN is defined, add output ports all_ones (1 bit), any_one (1 bit) and is_zero (1 bit).
REQ-030 SHALL compute all_ones, any_one and is_zero as the AND-reduce, OR-reduce and NOR-reduce of the stage-1 result; they travel with the result and are valid when out_valid is 1.
REQ-031 SHALL reset all_ones, any_one and is_zero to 0.
REQ-032 SHALL, when LOGIC_PIPE_REDUCE_EN is undefined, have none of these ports or their logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover: WIDTH=16, DEPTH=2, out_ready=1; apply op=001, a=16'hF0F0, b=16'hFF00 -> out=16'hF000 with out_valid=1 exactly 2 cycles after acceptance.
REQ-034 SHALL cover: all 8 ops with a=16'h00FF, b=16'h0F0F -> out = FF00, 000F, 0FFF, 0FF0, FFF0, F000, F00F, 00FF respectively, in order, back-to-back at one result per cycle.
REQ-035 SHALL cover: out_ready=0 with 3 accepts attempted at DEPTH=2 -> occupancy=2, in_ready=0, the third op stalls; then release out_ready -> results appear in order with no loss.
REQ-036 SHALL cover: reset asserted with occupancy=2 -> next cycle out_valid=0, occupancy=0, out=0; the first accept after reset produces only its own result.
REQ-037 SHALL cover: WIDTH=8, DEPTH=1, in_valid toggling every other cycle, out_ready random -> a scoreboard matches every result, and occupancy never exceeds 1.
REQ-038 SHALL cover, with LOGIC_PIPE_REDUCE_EN defined: op=111 with a=0 -> is_zero=1, any_one=0; a=16'hFFFF -> all_ones=1, is_zero=0.
